xbar_out_arb: RTL and testbench
===============================

XBAR_OUT_ARB -- requirements
Module: xbar_out_arb

Interface
REQ-001 SHALL have parameter NPORT, default 5, number of input ports (NPORT >= 2); for NPORT=5, bit 4 = Local, 3 = West, 2 = North, 1 = East, 0 = South.
REQ-002 SHALL have parameter DW, default 32, flit data width (DW >= 1).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  NPORT  per-port flit valid, already steered to this output.
REQ-006 SHALL have port in_data  input  NPORT*DW  per-port flit data, port i at bits [i*DW +: DW].
REQ-007 SHALL have port in_tail  input  NPORT  per-port last-flit-of-packet flag.
REQ-008 SHALL have port in_ready  output  NPORT  per-port accept; a flit transfers when in_valid[i] and in_ready[i] are both high.
REQ-009 SHALL have port out_valid  output  1  registered output flit valid.
REQ-010 SHALL have port out_data  output  DW  registered output flit data.
REQ-011 SHALL have port out_tail  output  1  registered output tail flag.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port grant  output  NPORT  one-hot current grant, or zero when none.
REQ-014 SHALL have port busy  output  1  high while a multi-flit packet holds the output.

Function
REQ-015 SHALL implement two states: IDLE (no owner) and LOCKED (owner register holds the granted port index).
REQ-016 In IDLE, SHALL select the first port with in_valid high, searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NPORT-1, 0, ...).
REQ-017 In LOCKED, SHALL select only the owner port, regardless of the other in_valid bits.
REQ-018 SHALL define load_en = !out_valid || out_ready.
REQ-019 SHALL drive in_ready[i] = (i is the selected port) && load_en; all other in_ready bits SHALL be 0.
REQ-020 On a transfer, SHALL load in_data, in_tail and out_valid=1 into the output register at the next edge (latency 1 cycle).
REQ-021 When load_en is high and no transfer occurs, SHALL clear out_valid at the next edge; out_data and out_tail are don't-care while out_valid=0.
REQ-022 While out_valid=1 and out_ready=0, out_valid, out_data and out_tail SHALL remain stable.
REQ-023 When out_ready=1 and a new transfer occur in the same cycle, SHALL replace the register contents with the new flit (full throughput, one flit per cycle).
REQ-024 IDLE->LOCKED: on a transfer with in_tail=0; owner = transferring port.
REQ-025 LOCKED->IDLE: on a transfer from the owner with in_tail=1.
REQ-026 A transfer with in_tail=1 while in IDLE (single-flit packet) SHALL leave the block in IDLE.
REQ-027 On every tail transfer from port i, SHALL set rr_ptr = (i+1) mod NPORT; rr_ptr SHALL not change at any other time.
REQ-028 If the owner drops in_valid mid-packet, SHALL stay LOCKED and SHALL keep all in_ready low for the other ports (wormhole hold).
REQ-029 grant SHALL be the one-hot owner in LOCKED, the one-hot selection in IDLE when any in_valid is high, and 0 otherwise; grant is independent of load_en.
REQ-030 busy SHALL be 1 exactly when state == LOCKED.

Reset
REQ-031 When rst_n=0 at a clock edge, SHALL set state=IDLE, rr_ptr=0, owner=0, out_valid=0, out_data=0, out_tail=0.
REQ-032 While rst_n=0, in_ready SHALL be all-zero (combinationally gated) so that no flit is accepted.
REQ-033 Reset asserted mid-packet SHALL drop the packet in progress, with no partial-state retention.

Verification
REQ-034 Ports 0, 2 and 4 all valid with single-flit packets, out_ready=1, from reset -> output order 0, 2, 4, 0, ...; rr_ptr after each = 1, 3, 0.
REQ-035 Port 3 sends a 4-flit packet (tail on the 4th) while port 1 is continuously valid -> four port-3 flits appear back-to-back with busy=1; port 1 is served only after the tail; busy=0 in the cycle after the tail transfer.
REQ-036 out_valid=1 with out_data=0xA5A5A5A5 and out_ready held 0 for 3 cycles -> out_data stable and in_ready all 0 for those cycles; first flit accepted in the cycle out_ready returns to 1.
REQ-037 Owner port 2 drops in_valid for 2 cycles mid-packet while port 0 is valid -> grant stays 5'b00100, in_ready[0]=0, out_valid=0 after drain; packet resumes afterwards.
REQ-038 rst_n=0 for 1 cycle during a LOCKED packet on port 4 -> next cycle busy=0, out_valid=0, rr_ptr=0; port 0 wins if valid.

Source files
------------

// File: rtl/xbar_out_arb.sv
// Crossbar output-port arbiter: round-robin packet (wormhole) arbitration over
// NPORT inputs feeding a single registered output stage with ready/valid flow control.
module xbar_out_arb #(
    parameter int NPORT = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    in_valid,
    input  logic [NPORT*DW-1:0] in_data,
    input  logic [NPORT-1:0]    in_tail,
    output logic [NPORT-1:0]    in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic                out_tail,
    input  logic                out_ready,
    output logic [NPORT-1:0]    grant,
    output logic                busy
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, rr_ptr_q;
    logic [PW-1:0] pick, sel;
    logic          pick_vld, sel_vld, load_en, xfer;
    logic [DW-1:0] data_arr [NPORT];

    logic          vld_p1, tail_p1;
    logic [DW-1:0] data_p1;

    // Port index a+k, wrapped into 0..NPORT-1 (a < NPORT, k < NPORT).
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NPORT) s = s - NPORT;
        return PW'(s);
    endfunction

    function automatic logic [NPORT-1:0] onehot(input logic [PW-1:0] idx);
        logic [NPORT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar i = 0; i < NPORT; i++) begin : g_split
        assign data_arr[i] = in_data[i*DW +: DW];
    end

    // Descending scan so the port closest to rr_ptr is the last (winning) hit.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (in_valid[wrap_inc(rr_ptr_q, k)]) begin
                pick     = wrap_inc(rr_ptr_q, k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        load_en = !vld_p1 || out_ready;
        sel     = pick;
        sel_vld = pick_vld;
        if (state_q == LOCKED) begin
            sel     = owner_q;
            sel_vld = 1'b1;
        end
        in_ready = (sel_vld && load_en && rst_n) ? onehot(sel) : '0;
        xfer     = sel_vld && in_valid[sel] && load_en && rst_n;
        if (state_q == LOCKED)
            grant = onehot(owner_q);
        else if (pick_vld)
            grant = onehot(pick);
        else
            grant = '0;
        busy    = (state_q == LOCKED);
        state_d = state_q;
        if (xfer)
            state_d = in_tail[sel] ? IDLE : LOCKED;
    end

    // Stage p1: arbitration state and the registered output flit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            tail_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer && state_q == IDLE)
                owner_q <= sel;
            if (xfer && in_tail[sel])
                rr_ptr_q <= wrap_inc(sel, 1);
            if (load_en) begin
                vld_p1 <= xfer;
                if (xfer) begin
                    data_p1 <= data_arr[sel];
                    tail_p1 <= in_tail[sel];
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_tail  = tail_p1;

endmodule

// File: tb/tb_xbar_out_arb.sv
// Bench for xbar_out_arb: directed scenarios plus random traffic, all compared
// every cycle against a packet-level arbitration model.
module tb_xbar_out_arb;

    localparam int NP = 5;
    localparam int DW = 32;

    logic             clk;
    logic             rst_n;
    logic [NP-1:0]    in_valid;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_tail;
    logic [NP-1:0]    in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_tail;
    logic             out_ready;
    logic [NP-1:0]    grant;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit            m_locked;
    int            m_owner;
    int            m_rr;
    bit            m_ov;
    bit            m_ot;
    logic [DW-1:0] m_od;

    xbar_out_arb #(.NPORT(NP), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tail  (out_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] v);
        in_data[p*DW +: DW] = v;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_ov     = 1'b0;
        m_ot     = 1'b0;
        m_od     = '0;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cyc();
        int            sel;
        bit            selv, load, xfer;
        logic [NP-1:0] er, eg;
        #1;
        load = !m_ov || out_ready;
        selv = 1'b0;
        sel  = 0;
        if (m_locked) begin
            sel  = m_owner;
            selv = 1'b1;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (!selv && in_valid[(m_rr + k) % NP]) begin
                    sel  = (m_rr + k) % NP;
                    selv = 1'b1;
                end
            end
        end
        er = '0;
        if (selv && load && rst_n) er[sel] = 1'b1;
        eg = '0;
        if (selv) eg[sel] = 1'b1;
        xfer = selv && in_valid[sel] && load && rst_n;

        chk("in_ready", 64'(in_ready), 64'(er));
        chk("grant", 64'(grant), 64'(eg));
        chk("busy", 64'(busy), 64'(m_locked));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", 64'(out_data), 64'(m_od));
            chk("out_tail", 64'(out_tail), 64'(m_ot));
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (load) begin
                m_ov = xfer;
                if (xfer) begin
                    m_od = in_data[sel*DW +: DW];
                    m_ot = in_tail[sel];
                end
            end
            if (xfer) begin
                if (in_tail[sel]) begin
                    m_rr     = (sel + 1) % NP;
                    m_locked = 1'b0;
                end else if (!m_locked) begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int order [4];
        order = '{0, 2, 4, 0};

        rst_n     = 1'b0;
        in_valid  = '0;
        in_tail   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) set_data(p, 32'h100 + p);
        @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state, including data cleared
        in_valid = 5'b11111;
        cyc();
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_tail", 64'(out_tail), 64'h0);
        rst_n    = 1'b1;
        in_valid = '0;
        cyc();

        // Round-robin over single-flit packets on ports 0, 2, 4
        in_valid = 5'b10101;
        in_tail  = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_order", 64'(out_data), 64'(32'h100 + order[i]));
        end

        // Back-pressure hold: A5 flit parked while out_ready is low
        out_ready = 1'b0;
        in_valid  = 5'b00000;
        cyc();
        in_valid = 5'b00001;
        set_data(0, 32'hA5A5A5A5);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        in_valid  = 5'b00010;
        set_data(1, 32'h11);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_data", 64'(out_data), 64'hA5A5A5A5);
            chk("hold_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        cyc();
        chk("resume_data", 64'(out_data), 64'h11);

        // 4-flit packet on port 3 with port 1 contending
        in_valid = 5'b01010;
        in_tail  = 5'b00010;
        set_data(1, 32'h111);
        for (int f = 0; f < 4; f++) begin
            in_tail[3] = (f == 3);
            set_data(3, 32'h300 + f);
            cyc();
            chk("pkt3_data", 64'(out_data), 64'(32'h300 + f));
            chk("pkt3_busy", 64'(busy), 64'(f < 3));
        end
        cyc();
        chk("after_pkt3", 64'(out_data), 64'h111);

        // Owner port 2 stalls mid-packet while port 0 waits
        in_valid = 5'b00100;
        in_tail  = 5'b00000;
        set_data(2, 32'h200);
        set_data(0, 32'h1000);
        cyc();
        in_valid = 5'b00001;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_grant", 64'(grant), 64'h04);
            chk("stall_ready0", 64'(in_ready[0]), 64'h0);
        end
        chk("stall_drain", 64'(out_valid), 64'h0);
        in_valid = 5'b00101;
        in_tail  = 5'b00100;
        set_data(2, 32'h201);
        cyc();
        chk("stall_resume", 64'(out_data), 64'h201);
        chk("stall_busy", 64'(busy), 64'h0);
        in_valid = '0;
        cyc();

        // Reset in the middle of a packet on port 4
        in_valid = 5'b10000;
        in_tail  = 5'b00000;
        cyc();
        cyc();
        chk("pre_rst_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        in_valid = 5'b10001;
        #1;
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_ovalid", 64'(out_valid), 64'h0);
        chk("post_rst_grant", 64'(grant), 64'h01);
        cyc();
        chk("post_rst_data", 64'(out_data), 64'h1000);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                in_tail[p] = ($urandom_range(0, 2) == 0);
                set_data(p, $urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
